// File: rtl/dp_pkg.sv
// Shared constants, types and helpers for the destination-port match arbiter.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package dp_pkg;

  localparam int PORT_WIDTH     = 16;
  localparam int NUM_RULE_ID    = 8;
  localparam int RULE_ID_WIDTH  = 3;
  // Eight {valid, rule_id} nibbles.
  localparam int RULE_SET_WIDTH = NUM_RULE_ID * (RULE_ID_WIDTH + 1);

  typedef enum logic [1:0] {
    RUN,
    DRAIN,
    HALT
  } fsm_state_t;

  typedef struct packed {
    logic                  vld;
    logic [PORT_WIDTH-1:0] port;
  } tree_in_t;

  // The tree sees all-zero when nothing is issued, never a stale port.
  function automatic tree_in_t pack_tree_in(input logic vld, input logic [PORT_WIDTH-1:0] port);
    tree_in_t t;
    t.vld  = vld;
    t.port = vld ? port : '0;
    return t;
  endfunction

endpackage

// File: rtl/dp_rr_arbiter.sv
// Round-robin arbiter: one-hot grant among req, scanning upward from a rotating pointer.
// Latency: grant is combinational from req; pointer moves on the clock after a grant.
// Backpressure: en=0 forces grant to zero and freezes the pointer.
//
// Ports:
//   clk, reset  clock and synchronous active-high reset (pointer -> 0)
//   req         per-requester request vector
//   en          allow a grant this cycle
//   grant       one-hot (or zero) grant
module dp_rr_arbiter #(
  parameter  int NUM_REQ = 4,
  localparam int PTR_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_REQ-1:0] req,
  input  logic               en,
  output logic [NUM_REQ-1:0] grant
);

  logic [PTR_W-1:0] ptr;
  logic [PTR_W-1:0] win;
  logic [PTR_W-1:0] idx;
  logic             found;
  int               idx_i;

  always_comb begin
    grant = '0;
    win   = '0;
    idx   = '0;
    idx_i = 0;
    found = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      // Wrap explicitly so non-power-of-two NUM_REQ scans correctly.
      idx_i = int'(ptr) + k;
      if (idx_i >= NUM_REQ) idx_i = idx_i - NUM_REQ;
      idx = PTR_W'(idx_i);
      if (en && !found && req[idx]) begin
        grant[idx] = 1'b1;
        win        = idx;
        found      = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr <= '0;
    end else if (found) begin
      ptr <= (win == PTR_W'(NUM_REQ - 1)) ? '0 : win + 1'b1;
    end
  end

endmodule

// File: rtl/dp_match_arbiter.sv
// Shares one dest-port range match tree between NUM_REQ requesters, round-robin, with a pause/drain quiesce FSM.
// Latency: handshake at T -> tree_in at T+1 -> response (id + rule set) at T+1+TREE_LAT.
// Backpressure: req_ready withheld while pausing/drained; responses have no backpressure.
//
// Ports:
//   clk, reset       clock, synchronous active-high reset (shared with the tree)
//   req_valid/ready  per-requester handshake; req_ready is one-hot or zero
//   req_port         per-requester 16-bit dest port, slot i = [16*i +: 16]
//   tree_in          registered {valid, port} to the match tree
//   tree_out         rule-ID set from the tree, TREE_LAT cycles after tree_in
//   rsp_valid/id     response strobe and owning requester
//   rsp_rules        tree_out while rsp_valid, else zero
//   pause_req        stop issuing and drain; halted=1 once nothing is in flight
// Optional: define DP_ARB_STATS_EN for stat_grants (per-requester grants) and stat_stall.
module dp_match_arbiter
  import dp_pkg::*;
#(
  parameter  int NUM_REQ  = 4,
  parameter  int TREE_LAT = 6,
  localparam int REQ_ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*PORT_WIDTH-1:0] req_port,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic [PORT_WIDTH:0]           tree_in,
  input  logic [RULE_SET_WIDTH-1:0]     tree_out,
  output logic                          rsp_valid,
  output logic [REQ_ID_W-1:0]           rsp_id,
  output logic [RULE_SET_WIDTH-1:0]     rsp_rules,
  input  logic                          pause_req,
  output logic                          halted
`ifdef DP_ARB_STATS_EN
  ,
  output logic [NUM_REQ*32-1:0]         stat_grants,
  output logic [31:0]                   stat_stall
`endif
);

  localparam int INF_W = $clog2(TREE_LAT + 2);

  typedef struct packed {
    logic                vld;
    logic [REQ_ID_W-1:0] id;
  } tag_t;

  fsm_state_t            state;
  logic                  grant_en;
  logic [NUM_REQ-1:0]    hs;
  logic                  issue;
  logic [REQ_ID_W-1:0]   issue_id;
  logic [PORT_WIDTH-1:0] issue_port;
  tree_in_t              tree_in_q;
  tag_t                  tag_line [TREE_LAT+1];
  tag_t                  tail;
  logic [INF_W-1:0]      inflight;
  logic                  drained;

  // Grants stop in the same cycle pause_req rises, and never during reset.
  assign grant_en = (state == RUN) && !pause_req && !reset;

  dp_rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_rr (
    .clk   (clk),
    .reset (reset),
    .req   (req_valid),
    .en    (grant_en),
    .grant (req_ready)
  );

  assign hs    = req_valid & req_ready;
  assign issue = |hs;

  always_comb begin
    issue_id   = '0;
    issue_port = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (hs[i]) begin
        issue_id   = REQ_ID_W'(i);
        issue_port = req_port[PORT_WIDTH*i +: PORT_WIDTH];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      tree_in_q <= '0;
    end else begin
      tree_in_q <= pack_tree_in(issue, issue_port);
    end
  end

  assign tree_in = tree_in_q;

  // Tag line is one stage longer than the tree: stage 0 sits alongside the
  // tree_in register, so the tail lines up with the matching tree_out.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k <= TREE_LAT; k++) tag_line[k] <= '0;
    end else begin
      tag_line[0] <= '{vld: issue, id: issue_id};
      for (int k = 1; k <= TREE_LAT; k++) tag_line[k] <= tag_line[k-1];
    end
  end

  assign tail      = tag_line[TREE_LAT];
  assign rsp_valid = tail.vld;
  assign rsp_id    = tail.id;
  assign rsp_rules = tail.vld ? tree_out : '0;

  always_ff @(posedge clk) begin
    if (reset) begin
      inflight <= '0;
    end else begin
      case ({issue, rsp_valid})
        2'b10:   inflight <= inflight + 1'b1;
        2'b01:   inflight <= inflight - 1'b1;
        default: inflight <= inflight;
      endcase
    end
  end

  // Counts this cycle's response as retired; no issue can happen outside RUN.
  assign drained = (inflight == INF_W'(rsp_valid));

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= RUN;
      halted <= 1'b0;
    end else begin
      case (state)
        RUN: begin
          halted <= 1'b0;
          if (pause_req) state <= DRAIN;
        end
        DRAIN: begin
          if (!pause_req) begin
            state <= RUN;
          end else if (drained) begin
            state  <= HALT;
            halted <= 1'b1;
          end
        end
        HALT: begin
          if (!pause_req) begin
            state  <= RUN;
            halted <= 1'b0;
          end
        end
        default: begin
          state  <= RUN;
          halted <= 1'b0;
        end
      endcase
    end
  end

`ifdef DP_ARB_STATS_EN
  logic [31:0] grant_cnt [NUM_REQ];
  logic [31:0] stall_cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_REQ; i++) grant_cnt[i] <= '0;
      stall_cnt <= '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (hs[i] && (grant_cnt[i] != '1)) grant_cnt[i] <= grant_cnt[i] + 1'b1;
      end
      if ((|req_valid) && !issue && (stall_cnt != '1)) stall_cnt <= stall_cnt + 1'b1;
    end
  end

  always_comb begin
    stat_grants = '0;
    for (int i = 0; i < NUM_REQ; i++) stat_grants[32*i +: 32] = grant_cnt[i];
  end

  assign stat_stall = stall_cnt;
`endif

endmodule
